// File: rtl/axi_slave_pkg.sv
// axi_slave_pkg: shared FSM state types and AXI response codes for axi_slave_mem.
package axi_slave_pkg;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
  typedef enum logic {R_IDLE, R_DATA} rstate_t;
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
endpackage

// File: rtl/axi_slave_mem_array.sv
// axi_slave_mem_array: word storage with per-byte write enables and a registered read port.
module axi_slave_mem_array #(
  parameter int DATA_WIDTH = 16,
  parameter int ADD_WIDTH  = 8
) (
  input  logic                                            i_clk,
  input  logic                                            i_rst_n,
  input  logic                                            i_we,
  input  logic [DATA_WIDTH/8-1:0]                         i_wstrb,
  input  logic [ADD_WIDTH-$clog2(DATA_WIDTH/8)-1:0]       i_widx,
  input  logic [DATA_WIDTH-1:0]                           i_wdata,
  input  logic                                            i_re,
  input  logic [ADD_WIDTH-$clog2(DATA_WIDTH/8)-1:0]       i_ridx,
  output logic [DATA_WIDTH-1:0]                           o_rdata
);
  localparam int NB = DATA_WIDTH / 8;
  localparam int IW = ADD_WIDTH - $clog2(NB);
  logic [DATA_WIDTH-1:0] r_mem [2**IW];
  logic [DATA_WIDTH-1:0] r_rdata;
  always_ff @(posedge i_clk)
    if (i_we)
      for (int b = 0; b < NB; b++)
        if (i_wstrb[b]) r_mem[i_widx][8*b +: 8] <= i_wdata[8*b +: 8];
  // The read register samples pre-write content when both ports hit one word.
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_rdata <= '0;
    else if (i_re) r_rdata <= r_mem[i_ridx];
  assign o_rdata = r_rdata;
endmodule

// File: rtl/axi_slave_mem.sv
// axi_slave_mem: AXI INCR-burst responder over byte-enabled memory, one write and one read in flight.
module axi_slave_mem
  import axi_slave_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADD_WIDTH  = 8,
  parameter int ID_WIDTH   = 8
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic [ADD_WIDTH-1:0]    awaddr,
  input  logic [3:0]              awlen,
  input  logic [2:0]              awsize,
  input  logic [ID_WIDTH-1:0]     awid,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wlast,
  input  logic [ID_WIDTH-1:0]     wid,
  input  logic                    wvalid,
  output logic                    wready,
  output logic [ID_WIDTH-1:0]     bid,
  output logic [1:0]              bresp,
  output logic                    bvalid,
  input  logic                    bready,
  input  logic [ADD_WIDTH-1:0]    araddr,
  input  logic [3:0]              arlen,
  input  logic [2:0]              arsize,
  input  logic [ID_WIDTH-1:0]     arid,
  input  logic                    arvalid,
  output logic                    arready,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [ID_WIDTH-1:0]     rid,
  output logic [1:0]              rresp,
  output logic                    rlast,
  output logic                    rvalid,
  input  logic                    rready
);
  localparam int LB = $clog2(DATA_WIDTH / 8);
  wstate_t r_wstate, w_wnext;
  rstate_t r_rstate, w_rnext;
  logic r_live;
  logic [ADD_WIDTH-1:0] r_waddr, r_raddr, w_winc, w_rinc, w_rload_addr;
  logic [3:0] r_awlen, r_wbeat, r_arlen, r_rbeat;
  logic [2:0] r_awsize, r_arsize;
  logic [ID_WIDTH-1:0] r_awid, r_arid;
  logic r_werr, r_rerr;
  logic [1:0] r_bresp;
  logic [DATA_WIDTH-1:0] w_mem_rdata;
  logic w_aw_hs, w_w_hs, w_ar_hs, w_r_hs, w_wlast_beat, w_wid_ok, w_beat_err, w_mem_we, w_ren;
  // r_live holds the readies low until the first edge after reset release.
  always_ff @(posedge aclk or negedge areset)
    if (!areset) begin
      r_wstate <= W_IDLE;
      r_rstate <= R_IDLE;
      r_live   <= 1'b0;
    end else begin
      r_wstate <= w_wnext;
      r_rstate <= w_rnext;
      r_live   <= 1'b1;
    end
  always_comb begin
    awready = r_live && r_wstate == W_IDLE;
    wready  = r_wstate == W_DATA;
    bvalid  = r_wstate == W_RESP;
    w_wnext = r_wstate == W_IDLE ? (r_live && awvalid ? W_DATA : W_IDLE)
            : r_wstate == W_DATA ? (wvalid && r_wbeat == r_awlen ? W_RESP : W_DATA)
            : (bready ? W_IDLE : W_RESP);
  end
  always_comb begin
    arready = r_live && r_rstate == R_IDLE;
    rvalid  = r_rstate == R_DATA;
    w_rnext = r_rstate == R_IDLE ? (r_live && arvalid ? R_DATA : R_IDLE)
            : (rready && r_rbeat == r_arlen ? R_IDLE : R_DATA);
  end
  assign w_aw_hs      = awvalid && awready;
  assign w_w_hs       = wvalid && wready;
  assign w_ar_hs      = arvalid && arready;
  assign w_r_hs       = rvalid && rready;
  assign w_wlast_beat = r_wbeat == r_awlen;
  assign w_wid_ok     = wid == r_awid;
  assign w_beat_err   = !w_wid_ok || (wlast != w_wlast_beat);
  assign w_mem_we     = w_w_hs && w_wid_ok && !(r_awsize > 3'(LB));
  assign w_winc       = ADD_WIDTH'(1) << r_awsize;
  assign w_rinc       = ADD_WIDTH'(1) << r_arsize;
  assign w_ren        = w_ar_hs || (w_r_hs && !rlast);
  assign w_rload_addr = w_ar_hs ? araddr : r_raddr + w_rinc;
  always_ff @(posedge aclk or negedge areset)
    if (!areset) begin
      r_waddr  <= '0;
      r_awlen  <= '0;
      r_awsize <= '0;
      r_awid   <= '0;
      r_wbeat  <= '0;
      r_werr   <= 1'b0;
      r_bresp  <= OKAY;
    end else begin
      if (w_aw_hs) begin
        r_waddr  <= awaddr;
        r_awlen  <= awlen;
        r_awsize <= awsize;
        r_awid   <= awid;
        r_wbeat  <= '0;
        r_werr   <= awsize > 3'(LB);
      end
      if (w_w_hs) begin
        r_waddr <= r_waddr + w_winc;
        r_wbeat <= r_wbeat + 4'd1;
        r_werr  <= r_werr || w_beat_err;
        if (w_wlast_beat) r_bresp <= (r_werr || w_beat_err) ? SLVERR : OKAY;
      end
    end
  always_ff @(posedge aclk or negedge areset)
    if (!areset) begin
      r_raddr  <= '0;
      r_arlen  <= '0;
      r_arsize <= '0;
      r_arid   <= '0;
      r_rbeat  <= '0;
      r_rerr   <= 1'b0;
    end else begin
      if (w_ar_hs) begin
        r_arlen  <= arlen;
        r_arsize <= arsize;
        r_arid   <= arid;
        r_rbeat  <= '0;
        r_rerr   <= arsize > 3'(LB);
      end
      if (w_ren) r_raddr <= w_rload_addr;
      if (w_r_hs) r_rbeat <= r_rbeat + 4'd1;
    end
  assign bid   = r_awid;
  assign bresp = r_bresp;
  assign rid   = r_arid;
  assign rlast = rvalid && r_rbeat == r_arlen;
  assign rresp = (rvalid && r_rerr) ? SLVERR : OKAY;
  assign rdata = (rvalid && !r_rerr) ? w_mem_rdata : '0;
  axi_slave_mem_array #(.DATA_WIDTH(DATA_WIDTH), .ADD_WIDTH(ADD_WIDTH)) u_mem (
    .i_clk   (aclk),
    .i_rst_n (areset),
    .i_we    (w_mem_we),
    .i_wstrb (wstrb),
    .i_widx  (r_waddr[ADD_WIDTH-1:LB]),
    .i_wdata (wdata),
    .i_re    (w_ren),
    .i_ridx  (w_rload_addr[ADD_WIDTH-1:LB]),
    .o_rdata (w_mem_rdata)
  );
endmodule

// File: tb/tb_axi_slave_mem.sv
// tb_axi_slave_mem: randomized AXI traffic against a byte-array memory model with a queue scoreboard.
module tb_axi_slave_mem;
  logic aclk = 1'b0, areset = 1'b0;
  logic [7:0] awaddr = '0, araddr = '0, awid = '0, wid = '0, arid = '0;
  logic [3:0] awlen = '0, arlen = '0;
  logic [2:0] awsize = '0, arsize = '0;
  logic awvalid = 1'b0, wvalid = 1'b0, wlast = 1'b0, arvalid = 1'b0, bready = 1'b0, rready = 1'b0;
  logic [15:0] wdata = '0;
  logic [1:0] wstrb = '0;
  logic awready, wready, bvalid, arready, rvalid, rlast;
  logic [7:0] bid, rid;
  logic [1:0] bresp, rresp;
  logic [15:0] rdata;

  axi_slave_mem #(.DATA_WIDTH(16), .ADD_WIDTH(8), .ID_WIDTH(8)) dut (
    .aclk(aclk), .areset(areset),
    .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awid(awid), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wid(wid), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arlen(arlen), .arsize(arsize), .arid(arid), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rid(rid), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  initial forever #5 aclk = ~aclk;
  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  int checks = 0, errors = 0;
  logic [7:0] mem_m [256];
  logic [9:0] exp_b [$];
  logic [26:0] exp_r [$];
  logic [15:0] wd [16];
  logic [1:0] ws [16];
  int b_mode = 0, r_mode = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", nm, act, want);
    end
  endtask

  function automatic logic [15:0] rd_model(input logic [7:0] a);
    logic [7:0] b;
    b = {a[7:1], 1'b0};
    return {mem_m[b + 8'd1], mem_m[b]};
  endfunction

  function automatic void wr_model(input logic [7:0] a, input logic [15:0] d, input logic [1:0] s);
    logic [7:0] b;
    b = {a[7:1], 1'b0};
    if (s[0]) mem_m[b] = d[7:0];
    if (s[1]) mem_m[b + 8'd1] = d[15:8];
  endfunction

  function automatic logic rdy(input int w);
    return w == 0 ? awready : w == 1 ? arready : wready;
  endfunction

  // Response-side ready drivers: 0 = always ready, 1 = random, 2 = held low / toggling.
  initial forever begin
    @(posedge aclk);
    #1;
    bready = b_mode == 0 ? 1'b1 : b_mode == 1 ? 1'($urandom % 2) : 1'b0;
    rready = r_mode == 0 ? 1'b1 : r_mode == 1 ? 1'($urandom % 2) : !rready;
  end

  logic [9:0] b_prev;
  logic [26:0] r_prev;
  bit b_stall = 0, r_stall = 0;
  always @(negedge aclk) begin
    if (!areset) begin
      b_stall = 0;
      r_stall = 0;
    end else begin
      if (b_stall) chk("b_hold", {bvalid, bid, bresp}, {1'b1, b_prev});
      if (r_stall) chk("r_hold", {rvalid, rdata, rid, rresp, rlast}, {1'b1, r_prev});
      if (bvalid && bready) begin
        if (exp_b.size() == 0) chk("b_spurious", 64'(bvalid), 0);
        else chk("b_resp", {bid, bresp}, exp_b.pop_front());
      end
      if (rvalid && rready) begin
        if (exp_r.size() == 0) chk("r_spurious", 64'(rvalid), 0);
        else chk("r_beat", {rdata, rid, rresp, rlast}, exp_r.pop_front());
      end
      b_stall = bvalid && !bready;
      b_prev  = {bid, bresp};
      r_stall = rvalid && !rready;
      r_prev  = {rdata, rid, rresp, rlast};
    end
  end

  task automatic wait_rdy(input int which);
    int t = 0;
    do begin
      @(negedge aclk);
      t++;
    end while (!rdy(which) && t < 200);
    chk("ready", 64'(rdy(which)), 1);
  endtask

  task automatic drain();
    int t = 0;
    while ((exp_b.size() + exp_r.size()) != 0 && t < 500) begin
      @(negedge aclk);
      t++;
    end
    chk("drain", 64'(exp_b.size() + exp_r.size()), 0);
  endtask

  task automatic do_write(input logic [7:0] addr, input logic [3:0] len, input logic [2:0] size,
                          input logic [7:0] id, input int bad_beat, input int last_pos);
    bit err;
    err = size > 3'd1;
    for (int b = 0; b <= int'(len); b++) begin
      if (b == bad_beat || ((b == last_pos) != (b == int'(len)))) err = 1;
      if (size <= 3'd1 && b != bad_beat) wr_model(addr + 8'(b << size), wd[b], ws[b]);
    end
    exp_b.push_back({id, err ? 2'b10 : 2'b00});
    @(posedge aclk);
    #1;
    awaddr = addr; awlen = len; awsize = size; awid = id; awvalid = 1'b1;
    wait_rdy(0);
    @(posedge aclk);
    #1 awvalid = 1'b0;
    for (int b = 0; b <= int'(len); b++) begin
      if ($urandom % 4 == 0) begin
        @(posedge aclk);
        #1;
      end
      wdata = wd[b]; wstrb = ws[b]; wid = (b == bad_beat) ? ~id : id; wlast = (b == last_pos);
      wvalid = 1'b1;
      wait_rdy(2);
      @(posedge aclk);
      #1 wvalid = 1'b0;
    end
    drain();
  endtask

  task automatic do_read(input logic [7:0] addr, input logic [3:0] len, input logic [2:0] size, input logic [7:0] id);
    for (int b = 0; b <= int'(len); b++)
      exp_r.push_back({size > 3'd1 ? 16'h0 : rd_model(addr + 8'(b << size)), id,
                       size > 3'd1 ? 2'b10 : 2'b00, b == int'(len)});
    @(posedge aclk);
    #1;
    araddr = addr; arlen = len; arsize = size; arid = id; arvalid = 1'b1;
    wait_rdy(1);
    @(posedge aclk);
    #1 arvalid = 1'b0;
    drain();
  endtask

  task automatic chk_reset_outputs();
    chk("rst_ready", {awready, arready, wready}, 0);
    chk("rst_valid", {bvalid, rvalid, rlast}, 0);
    chk("rst_resp", {bresp, rresp}, 0);
    chk("rst_ids", {bid, rid}, 0);
    chk("rst_rdata", rdata, 0);
  endtask

  initial begin
    #1 chk_reset_outputs();
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    areset = 1'b1;
    #1 chk("ready_before_edge", {awready, arready}, 0);
    @(posedge aclk);
    #1 chk("ready_after_edge", {awready, arready}, 2'b11);
    // Fill the whole memory so the model is fully known.
    for (int i = 0; i < 8; i++) begin
      for (int b = 0; b < 16; b++) begin wd[b] = 16'($urandom); ws[b] = 2'b11; end
      do_write(8'(i * 32), 4'd15, 3'd1, 8'(i), -1, 15);
    end
    wd[0] = 16'hA5C3; ws[0] = 2'b11;
    do_write(8'h10, 4'd0, 3'd1, 8'h5C, -1, 0);
    do_read(8'h10, 4'd0, 3'd1, 8'h21);
    for (int b = 0; b < 4; b++) begin wd[b] = 16'(b + 1); ws[b] = 2'b11; end
    do_write(8'hFC, 4'd3, 3'd1, 8'h07, -1, 3);
    do_read(8'hFC, 4'd3, 3'd1, 8'h08);
    wd[0] = 16'hFFFF; ws[0] = 2'b11;
    do_write(8'h20, 4'd0, 3'd1, 8'h01, -1, 0);
    wd[0] = 16'h1234; ws[0] = 2'b01;
    do_write(8'h20, 4'd0, 3'd1, 8'h02, -1, 0);
    do_read(8'h20, 4'd0, 3'd1, 8'h03);
    for (int b = 0; b < 4; b++) begin wd[b] = 16'($urandom); ws[b] = 2'b11; end
    do_write(8'h60, 4'd1, 3'd2, 8'h44, -1, 1);
    do_read(8'h60, 4'd3, 3'd1, 8'h45);
    do_write(8'h70, 4'd3, 3'd1, 8'h46, 1, 3);
    do_read(8'h70, 4'd3, 3'd1, 8'h47);
    do_read(8'h70, 4'd1, 3'd2, 8'h48);
    do_write(8'h90, 4'd2, 3'd1, 8'h49, -1, 1);
    do_read(8'h90, 4'd2, 3'd1, 8'h4A);
    // Backpressure: bready held low after bvalid, then rready toggling every cycle.
    b_mode = 2;
    wd[0] = 16'hBEEF; ws[0] = 2'b11;
    fork
      do_write(8'h40, 4'd0, 3'd1, 8'h33, -1, 0);
      begin
        int t = 0;
        while (!bvalid && t < 100) begin @(negedge aclk); t++; end
        repeat (5) @(posedge aclk);
        #2 b_mode = 0;
      end
    join
    r_mode = 2;
    do_read(8'hF8, 4'd7, 3'd1, 8'h34);
    r_mode = 0;
    // Write beat and read-beat load on the same word in the same cycle.
    @(posedge aclk);
    #1;
    awaddr = 8'h30; awlen = 4'd0; awsize = 3'd1; awid = 8'h61; awvalid = 1'b1;
    wait_rdy(0);
    @(posedge aclk);
    #1 awvalid = 1'b0;
    exp_r.push_back({rd_model(8'h30), 8'h62, 2'b00, 1'b1});
    wr_model(8'h30, 16'h5AA5, 2'b11);
    exp_b.push_back({8'h61, 2'b00});
    wdata = 16'h5AA5; wstrb = 2'b11; wid = 8'h61; wlast = 1'b1; wvalid = 1'b1;
    araddr = 8'h30; arlen = 4'd0; arsize = 3'd1; arid = 8'h62; arvalid = 1'b1;
    wait_rdy(2);
    chk("ar_concurrent", 64'(arready), 1);
    @(posedge aclk);
    #1 begin wvalid = 1'b0; arvalid = 1'b0; end
    drain();
    do_read(8'h30, 4'd0, 3'd1, 8'h63);
    // Randomized traffic with random response-side backpressure.
    b_mode = 1;
    r_mode = 1;
    for (int n = 0; n < 40; n++) begin
      logic [7:0] a;
      logic [3:0] l;
      logic [2:0] s;
      a = 8'($urandom);
      l = 4'($urandom % 8);
      s = ($urandom % 6 == 0) ? 3'd2 : 3'($urandom % 2);
      if ($urandom % 2 == 0) begin
        for (int b = 0; b < 16; b++) begin wd[b] = 16'($urandom); ws[b] = 2'($urandom); end
        do_write(a, l, s, 8'($urandom), ($urandom % 6 == 0) ? int'($urandom % (int'(l) + 1)) : -1,
                 ($urandom % 8 == 0) ? int'($urandom % (int'(l) + 1)) : int'(l));
      end else do_read(a, l, s, 8'($urandom));
    end
    b_mode = 0;
    r_mode = 0;
    // Reset after two of four beats: burst abandoned, no response.
    @(posedge aclk);
    #1;
    awaddr = 8'h80; awlen = 4'd3; awsize = 3'd1; awid = 8'h77; awvalid = 1'b1;
    wait_rdy(0);
    @(posedge aclk);
    #1 awvalid = 1'b0;
    for (int b = 0; b < 2; b++) begin
      wd[b] = 16'($urandom);
      wr_model(8'h80 + 8'(b * 2), wd[b], 2'b11);
      wdata = wd[b]; wstrb = 2'b11; wid = 8'h77; wlast = 1'b0; wvalid = 1'b1;
      wait_rdy(2);
      @(posedge aclk);
      #1 wvalid = 1'b0;
    end
    #2 areset = 1'b0;
    #1 chk_reset_outputs();
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    areset = 1'b1;
    #1 chk("mid_ready_before_edge", {awready, arready}, 0);
    @(posedge aclk);
    #1 chk("mid_ready_after_edge", {awready, arready}, 2'b11);
    repeat (10) @(negedge aclk);
    chk("mid_no_bvalid", 64'(bvalid), 0);
    do_read(8'h80, 4'd3, 3'd1, 8'h78);
    drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/axi_slave_mem.md
AXI_SLAVE_MEM -- requirements
Module: axi_slave_mem

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, data bus width in bits (multiple of 8).
REQ-002 SHALL have parameter ADD_WIDTH, default 8, byte-address width; memory holds 2^ADD_WIDTH bytes.
REQ-003 SHALL have parameter ID_WIDTH, default 8, transaction ID width.
REQ-004 SHALL have ports: aclk in 1, the single clock; areset in 1, asynchronous active-low reset.
REQ-005 SHALL have AW ports: awaddr in ADD_WIDTH; awlen in 4; awsize in 3; awid in ID_WIDTH; awvalid in 1; awready out 1.
REQ-006 SHALL have W ports: wdata in DATA_WIDTH; wstrb in DATA_WIDTH/8; wlast in 1; wid in ID_WIDTH; wvalid in 1; wready out 1.
REQ-007 SHALL have B ports: bid out ID_WIDTH; bresp out 2; bvalid out 1; bready in 1.
REQ-008 SHALL have AR ports: araddr in ADD_WIDTH; arlen in 4; arsize in 3; arid in ID_WIDTH; arvalid in 1; arready out 1.
REQ-009 SHALL have R ports: rdata out DATA_WIDTH; rid out ID_WIDTH; rresp out 2; rlast out 1; rvalid out 1; rready in 1.

Function
REQ-010 SHALL act as the AXI responder (slave) backed by byte-enabled memory; INCR bursts only, one outstanding write and one outstanding read; write and read paths independent.
REQ-011 Write FSM SHALL have states W_IDLE, W_DATA, W_RESP; awready=1 only in W_IDLE; wready=1 only in W_DATA; bvalid=1 only in W_RESP.
REQ-012 On awvalid&&awready SHALL capture awaddr/awlen/awsize/awid, clear beat counter, go to W_DATA next cycle.
REQ-013 Each wvalid&&wready beat SHALL write bytes where wstrb bit=1 to word index addr/(DATA_WIDTH/8), then addr += 2^awsize, modulo 2^ADD_WIDTH (wrap at top).
REQ-014 Beat awlen+1 SHALL move to W_RESP; wlast is not used for termination.
REQ-015 bresp SHALL be SLVERR (2'b10) if awsize > log2(DATA_WIDTH/8), any beat has wid!=awid (beat not written), or wlast mismatches final-beat position; else OKAY (2'b00); bid=captured awid.
REQ-016 awsize > log2(DATA_WIDTH/8) SHALL suppress all writes of that burst.
REQ-017 bvalid, bid, bresp SHALL hold stable until bready; on bvalid&&bready go W_IDLE, awready=1 next cycle.
REQ-018 Read FSM SHALL have states R_IDLE, R_DATA; arready=1 only in R_IDLE.
REQ-019 On arvalid&&arready SHALL capture AR fields and load first beat; rvalid=1 the following cycle (1-cycle latency).
REQ-020 rdata, rid, rresp, rlast SHALL hold stable while rvalid&&!rready.
REQ-021 On rvalid&&rready SHALL advance addr by 2^arsize (wrapping) and present next beat next cycle with no bubble; rlast=1 exactly on beat arlen+1.
REQ-022 After last beat handshake SHALL go R_IDLE, rvalid=0, arready=1 next cycle.
REQ-023 rresp SHALL be SLVERR with rdata=0 on every beat if arsize > log2(DATA_WIDTH/8); else OKAY.
REQ-024 Same-cycle write and read-beat load to same word: read SHALL return pre-write content.

Reset
REQ-025 areset low SHALL asynchronously force both FSMs idle, awready=0, arready=0, wready=0, bvalid=0, rvalid=0, rlast=0, bresp=0, rresp=0, bid=0, rid=0, rdata=0.
REQ-026 awready and arready SHALL assert on the first aclk edge after areset deasserts.
REQ-027 Memory contents SHALL NOT be cleared by reset; reset mid-burst SHALL abandon the burst with no response.

Structure
REQ-028 Package axi_slave_pkg SHALL hold write/read state enums and response constants OKAY=2'b00, SLVERR=2'b10.
REQ-029 Storage SHALL be sub-module axi_slave_mem_array: 2^ADD_WIDTH/(DATA_WIDTH/8) words, per-byte write enable, one write and one read port.

Verification
REQ-030 Single write: awaddr=8'h10, awlen=0, awsize=1, wdata=16'hA5C3, wstrb=2'b11 -> bresp=OKAY, bid=awid; read 8'h10 -> rdata=16'hA5C3, rlast=1.
REQ-031 Burst wrap: awaddr=8'hFC, awlen=3, awsize=1, data 1,2,3,4 -> words at 8'hFC,8'hFE,8'h00,8'h02; readback identical with rlast on beat 4 only.
REQ-032 Backpressure: bready low 5 cycles, rready toggled every cycle -> bvalid/bid/bresp and rdata/rlast stable while stalled, no beat lost or duplicated.
REQ-033 Strobe: write 16'hFFFF then 16'h1234 with wstrb=2'b01 -> read returns 16'hFF34.
REQ-034 Errors: awsize=2 -> bresp=SLVERR, memory unchanged; wid!=awid on beat 2 -> SLVERR, beat 2 not written; arsize=2 -> rresp=SLVERR, rdata=0.
REQ-035 Reset mid-burst after 2 of 4 beats -> all valids/readies 0 immediately, awready=arready=1 one cycle after release, no bvalid.
